// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and default widths.
package counter_seq_pkg;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_PCNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/counter_sequencer_count_core.sv
// WIDTH-bit count register: clear has priority over increment, otherwise the value holds.
module count_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] value
);

  // Count register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= {WIDTH{1'b0}};
    end else if (clr) begin
      value <= {WIDTH{1'b0}};
    end else if (en) begin
      value <= value + 1'b1;
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run/hold/done sequencer around a count register, with one-shot or periodic terminal events.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = DEF_PCNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [WIDTH-1:0]  limit,
  input  logic              auto_reload,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  seq_state_t        state_r;
  logic [WIDTH-1:0]  limit_r;
  logic              reload_r;
  logic              clr_s;
  logic              en_s;
  logic              at_limit_s;

  assign at_limit_s = (count == limit_r);

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_s),
    .en    (en_s),
    .value (count)
  );

  // Count register control, following the same event priority as the FSM.
  always_comb begin
    clr_s = 1'b0;
    en_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (stop || start) begin
          clr_s = 1'b1;
        end else begin
          clr_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          clr_s = 1'b1;
        end else if (pause) begin
          en_s = 1'b0;
        end else if (at_limit_s) begin
          clr_s = reload_r;
        end else begin
          en_s = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          clr_s = 1'b1;
        end else begin
          clr_s = 1'b0;
        end
      end
      default: begin
        clr_s = 1'b1;
      end
    endcase
  end

  // Sequencer state, latched run configuration and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      limit_r  <= {WIDTH{1'b0}};
      reload_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      periods  <= {PCNT_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (start) begin
            state_r  <= ST_RUN;
            limit_r  <= limit;
            reload_r <= auto_reload;
            periods  <= {PCNT_W{1'b0}};
            busy     <= 1'b1;
          end else begin
            state_r <= state_r;
            busy    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (pause) begin
            state_r <= ST_HOLD;
            busy    <= 1'b1;
          end else if (at_limit_s) begin
            done    <= 1'b1;
            periods <= periods + 1'b1;
            if (reload_r) begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              busy    <= 1'b0;
            end
          end else begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (stop) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (!pause) begin
            state_r <= ST_RUN;
            busy    <= 1'b1;
          end else begin
            state_r <= ST_HOLD;
            busy    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench: constant vector table, directed corner sequences and a random run against a reference model.
module tb_counter_sequencer;

  localparam int WIDTH  = 4;
  localparam int PCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              pause = 1'b0;
  logic [WIDTH-1:0]  limit = '0;
  logic              auto_reload = 1'b0;
  logic [WIDTH-1:0]  count;
  logic              busy;
  logic              done;
  logic [PCNT_W-1:0] periods;

  counter_sequencer #(.WIDTH(WIDTH), .PCNT_W(PCNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .limit(limit), .auto_reload(auto_reload),
    .count(count), .busy(busy), .done(done), .periods(periods)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: an active run is either counting or held; an inactive one keeps its count.
  bit m_act, m_held, m_auto, m_done;
  int m_cnt, m_lim, m_per;

  typedef struct {
    bit st; bit sp; bit pa; int lim; bit ar;
    int e_cnt; bit e_busy; bit e_done; int e_per;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit st, bit sp, bit pa, int lim, bit ar,
                              int ec, bit eb, bit ed, int ep);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.lim = lim; v.ar = ar;
    v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_per = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input bit st, input bit sp, input bit pa,
                            input int lim, input bit ar, input bit rs);
    m_done = 1'b0;
    if (rs) begin
      m_act = 0; m_held = 0; m_cnt = 0; m_per = 0; m_lim = 0; m_auto = 0;
    end else if (!m_act) begin
      if (sp) m_cnt = 0;
      else if (st) begin
        m_act = 1; m_held = 0; m_cnt = 0; m_per = 0;
        m_lim = lim % (1 << WIDTH); m_auto = ar;
      end
    end else if (sp) begin
      m_act = 0; m_held = 0; m_cnt = 0;
    end else if (m_held) begin
      m_held = pa;
    end else if (pa) begin
      m_held = 1;
    end else if (m_cnt == m_lim) begin
      m_per = (m_per + 1) % (1 << PCNT_W);
      m_done = 1;
      if (m_auto) m_cnt = 0;
      else m_act = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit pa,
                      input int lim, input bit ar, input bit rs);
    start = st; stop = sp; pause = pa; limit = lim[WIDTH-1:0];
    auto_reload = ar; rst = rs;
    @(posedge clk);
    model_step(st, sp, pa, lim, ar, rs);
    #1;
    chk("model_count", int'(count), m_cnt);
    chk("model_busy", int'(busy), int'(m_act));
    chk("model_done", int'(done), int'(m_done));
    chk("model_periods", int'(periods), m_per);
  endtask

  initial begin
    bit seen;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 9, 1, 1);
    chk("reset_count", int'(count), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_periods", int'(periods), 0);

    // One-shot limit 5, then stop+start in DONE, then periodic limit 3 with mid-run input changes
    tbl.push_back(mk(1, 0, 0, 5, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0, 0, 0, 12, 1, k, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 5, 0, 5, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 5, 0, 5, 0, 0, 1));
    tbl.push_back(mk(1, 1, 0, 5, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 3, 1, 0, 1, 0, 0));
    for (int k = 1; k <= 12; k++)
      tbl.push_back(mk(0, 0, 0, 7, 0, k % 4, 1, (k % 4) == 0, k / 4));
    tbl.push_back(mk(0, 1, 0, 3, 1, 0, 0, 0, 3));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].lim, tbl[i].ar, 0);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_done", i), int'(done), int'(tbl[i].e_done));
      chk($sformatf("tbl%0d_periods", i), int'(periods), tbl[i].e_per);
    end

    // Pause for three edges at count 4 with limit 9
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 9, 0, 0);
    repeat (4) step(0, 0, 0, 9, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1, 9, 0, 0);
      chk("pause_hold_count", int'(count), 4);
      chk("pause_hold_busy", int'(busy), 1);
    end
    seen = 0;
    for (int k = 8; k < 40 && !seen; k++) begin
      step(0, 0, 0, 9, 0, 0);
      if (done) begin
        seen = 1;
        chk("pause_done_edge", k, 14);
      end
    end
    if (!seen) chk("pause_done_seen", 0, 1);

    // Pause coincident with the terminal cycle
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 2, 0, 0);
    repeat (2) step(0, 0, 0, 2, 0, 0);
    step(0, 0, 1, 2, 0, 0);
    chk("term_pause_done", int'(done), 0);
    step(0, 0, 0, 2, 0, 0);
    chk("term_resume_done", int'(done), 0);
    step(0, 0, 0, 2, 0, 0);
    chk("term_after_done", int'(done), 1);
    chk("term_after_count", int'(count), 2);

    // Stop at count 7 with limit 15, then restart
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 15, 0, 0);
    repeat (7) step(0, 0, 0, 15, 0, 0);
    chk("stop_pre_count", int'(count), 7);
    step(0, 1, 0, 15, 0, 0);
    chk("stop_count", int'(count), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    step(0, 0, 0, 15, 0, 0);
    chk("stop_idle_done", int'(done), 0);
    step(1, 0, 0, 15, 0, 0);
    chk("restart_count", int'(count), 0);
    chk("restart_busy", int'(busy), 1);
    step(0, 0, 0, 15, 0, 0);
    chk("restart_count1", int'(count), 1);

    // Limit 0 periodic, then reset mid-run with start held
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0, 1, 0);
      chk("lim0_done", int'(done), 1);
      chk("lim0_count", int'(count), 0);
      chk("lim0_periods", int'(periods), k);
    end
    step(1, 0, 0, 5, 1, 1);
    step(1, 0, 0, 5, 1, 1);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_periods", int'(periods), 0);
    step(0, 0, 0, 5, 1, 0);
    chk("rst_after_busy", int'(busy), 0);

    // Start while busy with a new limit is ignored
    step(1, 0, 0, 6, 0, 0);
    repeat (2) step(0, 0, 0, 6, 0, 0);
    step(1, 0, 0, 2, 1, 0);
    chk("busy_start_count", int'(count), 3);
    seen = 0;
    for (int k = 4; k < 30 && !seen; k++) begin
      step(0, 0, 0, 2, 1, 0);
      if (done) begin
        seen = 1;
        chk("busy_start_done_edge", k, 7);
        chk("busy_start_done_count", int'(count), 6);
      end
    end
    if (!seen) chk("busy_start_done_seen", 0, 1);

    // Period counter wrap
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1, 0);
    repeat (256) step(0, 0, 0, 0, 1, 0);
    chk("wrap_periods0", int'(periods), 0);
    step(0, 0, 0, 0, 1, 0);
    chk("wrap_periods1", int'(periods), 1);

    // Random traffic against the model
    step(0, 0, 0, 0, 0, 1);
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(7) == 0, $urandom_range(19) == 0, $urandom_range(4) == 0,
           int'($urandom_range(15)), 1'($urandom_range(1)), $urandom_range(149) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
